fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS32 pipeline, directly upstream of the instruction memory. It owns the word-addressed program counter and drives the 8-bit instruction-memory address. It captures the 32-bit instruction that memory returns combinationally into the IF/ID pipeline register. It handles stall, branch/jump redirect with a one-slot flush, halt, and a fetched-instruction counter.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the word-addressed PC, registers the
// fetched word into IF/ID, and handles stall, redirect-with-flush and halt.
module fetch_stage #(
   parameter logic [7:0] RESET_PC = 8'd0,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [7:0]       redirect_pc,
   input  logic             halt,
   output logic [7:0]       imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      ifid_instr,
   output logic [7:0]       ifid_pc_plus1,
   output logic             ifid_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t     state;
   logic [7:0] pc;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   assign imem_addr = pc;

   // Fetch state machine; priority in RUN is redirect, halt, stall, advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RUN;
         pc            <= RESET_PC;
         ifid_instr    <= 32'h0000_0000;
         ifid_pc_plus1 <= 8'd0;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
         fetch_count   <= {CNT_W{1'b0}};
      end else begin
         case (state)
            RUN: begin
               if (redirect) begin
                  pc         <= redirect_pc;
                  ifid_instr <= 32'h0000_0000;
                  ifid_valid <= 1'b0;
               end else if (halt) begin
                  state      <= HALTED;
                  halted     <= 1'b1;
                  ifid_instr <= 32'h0000_0000;
                  ifid_valid <= 1'b0;
               end else if (stall) begin
                  pc         <= pc;
                  ifid_instr <= ifid_instr;
                  ifid_valid <= ifid_valid;
               end else begin
                  ifid_instr    <= imem_data;
                  ifid_pc_plus1 <= pc + 8'd1;
                  ifid_valid    <= 1'b1;
                  pc            <= pc + 8'd1;
                  // Counter sticks at all-ones rather than wrapping.
                  if (fetch_count != CNT_MAX) begin
                     fetch_count <= fetch_count + CNT_ONE;
                  end else begin
                     fetch_count <= fetch_count;
                  end
               end
            end
            HALTED: begin
               halted     <= 1'b1;
               ifid_instr <= 32'h0000_0000;
               ifid_valid <= 1'b0;
            end
            default: begin
               // An illegal encoding parks the stage safely until reset.
               state      <= HALTED;
               halted     <= 1'b1;
               ifid_instr <= 32'h0000_0000;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_fetch_stage;

   localparam int CW = 4;
   localparam int VW = 8 + 32 + 8 + 1 + 1 + CW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          redirect = 1'b0;
   logic [7:0]    redirect_pc = 8'd0;
   logic          halt = 1'b0;
   logic [7:0]    imem_addr;
   logic [31:0]   imem_data;
   logic [31:0]   ifid_instr;
   logic [7:0]    ifid_pc_plus1;
   logic          ifid_valid;
   logic          halted;
   logic [CW-1:0] fetch_count;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: architectural view of the stage
   logic [7:0]    m_pc;
   logic [31:0]   m_instr;
   logic [7:0]    m_pp1;
   logic          m_valid;
   logic          m_halted;
   int            m_cnt;

   fetch_stage #(.RESET_PC(8'd0), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .imem_addr(imem_addr),
      .imem_data(imem_data), .ifid_instr(ifid_instr),
      .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;
   assign imem_data = mem[imem_addr];

   function automatic logic [VW-1:0] act();
      return {imem_addr, ifid_instr, ifid_pc_plus1, ifid_valid, halted, fetch_count};
   endfunction

   function automatic logic [VW-1:0] exp();
      logic [CW-1:0] c;
      c = CW'(m_cnt);
      return {m_pc, m_instr, m_pp1, m_valid, m_halted, c};
   endfunction

   task automatic model_reset();
      m_pc = 8'd0; m_instr = 32'h0; m_pp1 = 8'd0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic r, input logic [7:0] rp, input logic h, input logic s);
      if (m_halted) begin
         m_instr = 32'h0; m_valid = 1'b0;
      end else if (r) begin
         m_pc = rp; m_instr = 32'h0; m_valid = 1'b0;
      end else if (h) begin
         m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
         m_instr = mem[m_pc];
         m_pp1   = 8'((int'(m_pc) + 1) % 256);
         m_valid = 1'b1;
         m_pc    = m_pp1;
         if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step(input logic r, input logic [7:0] rp, input logic h, input logic s);
      redirect = r; redirect_pc = rp; halt = h; stall = s;
      @(posedge clk);
      model_edge(r, rp, h, s);
      #1;
      redirect = 1'b0; halt = 1'b0; stall = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      #2;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (act() !== exp() || imem_addr !== 8'd0 || ifid_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got %h expected %h", i, act(), exp());
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'd0, 1'b0, 1'b0);
         n_checks++;
         if (act() !== exp() || ifid_instr !== mem[i] || ifid_pc_plus1 !== 8'(i + 1)) begin
            n_fail++;
            $display("FAIL seq_fetch[%0d]: got %h expected %h", i, act(), exp());
         end
      end
      n_checks++;
      if (fetch_count !== 4'd3) begin
         n_fail++;
         $display("FAIL seq_count: got %0d expected 3", fetch_count);
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 8'd0, 1'b0, 1'b1);
         n_checks++;
         if (act() !== exp() || ifid_instr !== mem[1] || imem_addr !== 8'd2 || fetch_count !== 4'd2) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", i, act(), exp());
         end
      end
      step(1'b0, 8'd0, 1'b0, 1'b0);
      n_checks++;
      if (act() !== exp() || ifid_instr !== mem[2] || ifid_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got %h expected %h", act(), exp());
      end
   endtask

   task automatic test_redirect();
      // pc is 3 here
      step(1'b1, 8'd5, 1'b0, 1'b0);
      n_checks++;
      if (act() !== exp() || imem_addr !== 8'd5 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
         n_fail++;
         $display("FAIL redirect_flush: got %h expected %h", act(), exp());
      end
      step(1'b0, 8'd0, 1'b0, 1'b0);
      n_checks++;
      if (act() !== exp() || ifid_instr !== mem[5] || ifid_pc_plus1 !== 8'd6) begin
         n_fail++;
         $display("FAIL redirect_target: got %h expected %h", act(), exp());
      end
      step(1'b1, 8'd0, 1'b0, 1'b1);
      n_checks++;
      if (act() !== exp() || imem_addr !== 8'd0 || ifid_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_vs_stall: got %h expected %h", act(), exp());
      end
      step(1'b1, 8'd9, 1'b1, 1'b0);
      n_checks++;
      if (act() !== exp() || halted !== 1'b0 || imem_addr !== 8'd9) begin
         n_fail++;
         $display("FAIL redirect_vs_halt: got %h expected %h", act(), exp());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] pp [3];
      pp[0] = 8'd255; pp[1] = 8'd0; pp[2] = 8'd1;
      step(1'b1, 8'd254, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'd0, 1'b0, 1'b0);
         n_checks++;
         if (act() !== exp() || ifid_pc_plus1 !== pp[i] || imem_addr !== pp[i]) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got %h expected %h", i, act(), exp());
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
      n_checks++;
      if (act() !== exp() || fetch_count !== 4'hF) begin
         n_fail++;
         $display("FAIL count_saturate: got %h expected %h", act(), exp());
      end
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      n_checks++;
      if (act() !== exp() || halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 8'd4) begin
         n_fail++;
         $display("FAIL halt_enter: got %h expected %h", act(), exp());
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'd40 + 8'(i)), 1'b0, 1'(i % 2));
         n_checks++;
         if (act() !== exp() || imem_addr !== 8'd4 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_ignore[%0d]: got %h expected %h", i, act(), exp());
         end
      end
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (act() !== exp() || imem_addr !== 8'd0 || halted !== 1'b0 || fetch_count !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", act(), exp());
      end
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 8'd0, 1'b0, 1'b0);
      n_checks++;
      if (act() !== exp() || ifid_instr !== mem[0] || imem_addr !== 8'd1) begin
         n_fail++;
         $display("FAIL restart: got %h expected %h", act(), exp());
      end
   endtask

   task automatic test_random();
      logic r, h, s;
      logic [7:0] rp;
      for (int i = 0; i < 500; i++) begin
         if (m_halted && $urandom_range(0, 7) == 0) begin
            do_reset();
         end
         r  = ($urandom_range(0, 7) == 0);
         rp = 8'($urandom);
         h  = ($urandom_range(0, 40) == 0);
         s  = ($urandom_range(0, 3) == 0);
         step(r, rp, h, s);
         n_checks++;
         if (act() !== exp()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h expected %h", i, act(), exp());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      test_reset();
      test_stall();
      test_redirect();
      test_wrap();
      test_saturate();
      test_halt();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
